// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, constants and helpers for the instruction memory loader
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } imem_state_e;

    localparam int RD_LAT_MAX = 4;
    localparam int MEMADR_W   = 26;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - instruction RAM, one synchronous write port and one asynchronous read port
module imem_ram
    import imem_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int INST_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [INST_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [INST_W-1:0] o_rdata
);

    logic [INST_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory with boot loader copying a half-word image from the external bus
module imem_loader
    import imem_pkg::*;
#(
    parameter int                    ADDR_W    = 11,
    parameter int                    EXT_W     = 16,
    parameter int                    INST_W    = 32,
    parameter logic [MEMADR_W-1:0]   BASE_ADR  = 26'h000000,
    parameter int                    RD_LAT    = 1,
    parameter bit                    BYTE_SWAP = 1'b1,
    parameter bit                    AUTO_LOAD = 1'b1
) (
    input  logic                clk125,
    input  logic                clrn,
    input  logic                start,
    output logic [MEMADR_W-1:0] MemAdr,
    input  logic [EXT_W-1:0]    MemDB,
    input  logic [31:0]         a,
    output logic [INST_W-1:0]   inst,
    output logic                busy,
    output logic                done
);

    localparam int K_W = ADDR_W + 1;
    localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
    localparam logic [K_W-1:0] K_LAST = {K_W{1'b1}};

    imem_state_e          r_state;
    imem_state_e          w_state_nxt;
    logic [K_W-1:0]       r_k;
    logic [MEMADR_W-1:0]  r_memadr;
    logic                 r_auto;
    logic [EXT_W-1:0]     r_low;

    logic                 w_issue;
    logic                 w_load_go;
    logic                 w_ret_vld;
    logic [K_W-1:0]       w_ret_k;
    logic                 w_ret_last;
    logic                 w_we;
    logic [INST_W-1:0]    w_rdata;
    logic [INST_W-1:0]    w_view;
    logic                 w_unused;

    assign w_issue    = (r_state == ST_LOAD);
    assign w_ret_last = w_ret_vld && (w_ret_k == K_LAST);
    assign w_load_go  = (w_state_nxt == ST_LOAD) && (r_state != ST_LOAD);

    // A token carries the issue index; it retires when its half-word is on MemDB.
    generate
        if (LAT == 1) begin : g_lat1
            assign w_ret_vld = w_issue;
            assign w_ret_k   = r_k;
        end else begin : g_latn
            logic [LAT-2:0] r_pv;
            logic [K_W-1:0] r_pk [LAT-1];

            always_ff @(posedge clk125 or negedge clrn) begin
                if (!clrn) begin
                    r_pv <= '0;
                    for (int i = 0; i < LAT - 1; i++) begin
                        r_pk[i] <= '0;
                    end
                end else begin
                    r_pv[0] <= w_issue;
                    r_pk[0] <= r_k;
                    for (int i = 1; i < LAT - 1; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pk[i] <= r_pk[i-1];
                    end
                end
            end

            assign w_ret_vld = r_pv[LAT-2];
            assign w_ret_k   = r_pk[LAT-2];
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_auto || start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_ret_last) begin
                    w_state_nxt = ST_DONE;
                end else if (r_k == K_LAST) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_ret_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk125 or negedge clrn) begin
        if (!clrn) begin
            r_state  <= ST_IDLE;
            r_k      <= '0;
            r_memadr <= BASE_ADR;
            r_auto   <= AUTO_LOAD;
            r_low    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_go) begin
                r_k      <= '0;
                r_memadr <= BASE_ADR;
                r_auto   <= 1'b0;
            end else if (w_issue && (r_k != K_LAST)) begin
                r_k      <= r_k + 1'b1;
                r_memadr <= r_memadr + 1'b1;
            end
            if (w_ret_vld && !w_ret_k[0]) begin
                r_low <= MemDB;
            end
        end
    end

    // Odd half-word completes the instruction: one full-width write per word.
    assign w_we = w_ret_vld && w_ret_k[0];

    imem_ram #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_ram (
        .i_clk   (clk125),
        .i_we    (w_we),
        .i_waddr (w_ret_k[K_W-1:1]),
        .i_wdata ({MemDB, r_low}),
        .i_raddr (a[ADDR_W+1:2]),
        .o_rdata (w_rdata)
    );

    assign w_view   = BYTE_SWAP ? bswap32(w_rdata) : w_rdata;
    assign w_unused = ^{a[31:ADDR_W+2], a[1:0]};

    assign MemAdr = r_memadr;
    assign busy   = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    assign done   = (r_state == ST_DONE);
    assign inst   = busy ? '0 : w_view;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader across several configurations
module tb_imem_loader;

    typedef struct {
        int          unit;
        logic [31:0] a;
        logic [31:0] exp;
    } rd_vec_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic        clrn5;
    logic        start0;
    logic        start4;
    logic [31:0] a;
    logic [15:0] salt4;
    logic [15:0] salt5;

    logic [25:0] adr1, adr2, adr3, adr4, adr5, adr6;
    logic [15:0] db1, db2, db3, db4, db5, db6;
    logic [31:0] inst1, inst2, inst3, inst4, inst5, inst6;
    logic        busy1, busy2, busy3, busy4, busy5, busy6;
    logic        done1, done2, done3, done4, done5, done6;
    logic [25:0] d3a, d3b, d4a, d5a;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        d3a <= adr3;
        d3b <= d3a;
        d4a <= adr4;
        d5a <= adr5;
    end

    assign db1 = adr1[15:0];
    assign db2 = adr2[15:0];
    assign db3 = d3b[15:0];
    assign db4 = d4a[15:0] ^ salt4;
    assign db5 = d5a[15:0] ^ salt5;
    assign db6 = adr6[15:0];

    imem_loader #(.ADDR_W(3), .RD_LAT(1), .BASE_ADR(26'h0), .BYTE_SWAP(1'b0), .AUTO_LOAD(1'b1)) u1 (
        .clk125(clk), .clrn(clrn), .start(start0), .MemAdr(adr1), .MemDB(db1),
        .a(a), .inst(inst1), .busy(busy1), .done(done1));
    imem_loader #(.ADDR_W(3), .RD_LAT(1), .BASE_ADR(26'h0), .BYTE_SWAP(1'b1), .AUTO_LOAD(1'b1)) u2 (
        .clk125(clk), .clrn(clrn), .start(start0), .MemAdr(adr2), .MemDB(db2),
        .a(a), .inst(inst2), .busy(busy2), .done(done2));
    imem_loader #(.ADDR_W(3), .RD_LAT(3), .BASE_ADR(26'h100000), .BYTE_SWAP(1'b0), .AUTO_LOAD(1'b1)) u3 (
        .clk125(clk), .clrn(clrn), .start(start0), .MemAdr(adr3), .MemDB(db3),
        .a(a), .inst(inst3), .busy(busy3), .done(done3));
    imem_loader #(.ADDR_W(3), .RD_LAT(2), .BASE_ADR(26'h0), .BYTE_SWAP(1'b0), .AUTO_LOAD(1'b0)) u4 (
        .clk125(clk), .clrn(clrn), .start(start4), .MemAdr(adr4), .MemDB(db4),
        .a(a), .inst(inst4), .busy(busy4), .done(done4));
    imem_loader #(.ADDR_W(3), .RD_LAT(2), .BASE_ADR(26'h0), .BYTE_SWAP(1'b0), .AUTO_LOAD(1'b1)) u5 (
        .clk125(clk), .clrn(clrn5), .start(start0), .MemAdr(adr5), .MemDB(db5),
        .a(a), .inst(inst5), .busy(busy5), .done(done5));
    imem_loader #(.ADDR_W(3), .RD_LAT(1), .BASE_ADR(26'h3FFFFFE), .BYTE_SWAP(1'b0), .AUTO_LOAD(1'b1)) u6 (
        .clk125(clk), .clrn(clrn), .start(start0), .MemAdr(adr6), .MemDB(db6),
        .a(a), .inst(inst6), .busy(busy6), .done(done6));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input int unit);
        case (unit)
            1:       return inst1;
            2:       return inst2;
            3:       return inst3;
            4:       return inst4;
            5:       return inst5;
            default: return inst6;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_vec_t     vecs [12];
        int          d1_at;
        int          d3_at;
        int          d6_at;
        int          idle4_bad;
        int          seq_bad;
        int          c4;
        int          c5;
        logic [25:0] e6;

        vecs = '{
            '{1, 32'h0000_0008, 32'h0005_0004},
            '{1, 32'h0000_0000, 32'h0001_0000},
            '{1, 32'h0000_001C, 32'h000F_000E},
            '{2, 32'h0000_0008, 32'h0400_0500},
            '{2, 32'h0000_0048, 32'h0400_0500},
            '{2, 32'h0000_000B, 32'h0400_0500},
            '{2, 32'h0000_001C, 32'h0E00_0F00},
            '{3, 32'h0000_0014, 32'h000B_000A},
            '{3, 32'h0000_0000, 32'h0001_0000},
            '{6, 32'h0000_0000, 32'hFFFF_FFFE},
            '{6, 32'h0000_0004, 32'h0001_0000},
            '{6, 32'h0000_001C, 32'h000D_000C}
        };

        clrn   = 1'b0;
        clrn5  = 1'b0;
        start0 = 1'b0;
        start4 = 1'b0;
        a      = 32'h0;
        salt4  = 16'h1111;
        salt5  = 16'h00FF;
        d1_at  = -1;
        d3_at  = -1;
        d6_at  = -1;
        idle4_bad = 0;

        repeat (2) tick;
        chk("rst_adr1", {6'b0, adr1}, 32'h0);
        chk("rst_adr3", {6'b0, adr3}, 32'h0010_0000);
        chk("rst_adr6", {6'b0, adr6}, 32'h03FF_FFFE);
        chk("rst_busy1", {31'b0, busy1}, 32'h0);
        chk("rst_done1", {31'b0, done1}, 32'h0);

        #2 clrn = 1'b1;
        for (int n = 0; n < 25; n++) begin
            tick;
            if (n <= 15) begin
                e6 = 26'h3FFFFFE + 26'(n);
                chk("seq_adr1", {6'b0, adr1}, n);
                chk("seq_adr3", {6'b0, adr3}, 32'h0010_0000 + n);
                chk("seq_adr6", {6'b0, adr6}, {6'b0, e6});
            end
            if (n == 5) begin
                chk("busy1_mid", {31'b0, busy1}, 32'h1);
                chk("inst1_masked", inst1, 32'h0);
            end
            if (n == 20) chk("adr1_hold", {6'b0, adr1}, 32'hF);
            if (done1 && d1_at < 0) d1_at = n;
            if (done3 && d3_at < 0) d3_at = n;
            if (done6 && d6_at < 0) d6_at = n;
            if (busy4 || adr4 != 26'h0) idle4_bad++;
        end
        chk("load_cycles1", d1_at + 1, 17);
        chk("load_cycles3", d3_at + 1, 19);
        chk("load_cycles6", d6_at + 1, 17);
        chk("idle4_quiet", idle4_bad, 0);
        chk("busy1_end", {31'b0, busy1}, 32'h0);

        foreach (vecs[i]) begin
            a = vecs[i].a;
            #1;
            chk($sformatf("read_u%0d_a%h", vecs[i].unit, vecs[i].a), inst_of(vecs[i].unit), vecs[i].exp);
        end

        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        chk("u4_first_adr", {6'b0, adr4}, 32'h0);
        chk("u4_busy", {31'b0, busy4}, 32'h1);
        seq_bad = 0;
        c4 = 0;
        while (done4 !== 1'b1 && c4 < 40) begin
            if (c4 == 4) start4 = 1'b1;
            tick;
            start4 = 1'b0;
            c4++;
            if (c4 <= 15 && adr4 !== 26'(c4)) seq_bad++;
        end
        chk("u4_seq", seq_bad, 0);
        chk("u4_load_cycles", c4 + 1, 18);
        a = 32'hC;
        #1;
        chk("u4_word3", inst4, 32'h1116_1117);

        salt4  = 16'hA5A5;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        chk("u4_reload_done_low", {31'b0, done4}, 32'h0);
        chk("u4_reload_busy", {31'b0, busy4}, 32'h1);
        chk("u4_reload_adr", {6'b0, adr4}, 32'h0);
        chk("u4_reload_masked", inst4, 32'h0);
        c4 = 0;
        while (done4 !== 1'b1 && c4 < 40) begin
            tick;
            c4++;
        end
        chk("u4_reload_done", {31'b0, done4}, 32'h1);
        chk("u4_reload_word3", inst4, 32'hA5A2_A5A3);
        a = 32'h0;
        #1;
        chk("u4_reload_word0", inst4, 32'hA5A4_A5A5);

        #2 clrn5 = 1'b1;
        c5 = 0;
        while (adr5 !== 26'd7 && c5 < 30) begin
            tick;
            c5++;
        end
        chk("u5_reach_idx7", {6'b0, adr5}, 32'h7);
        clrn5 = 1'b0;
        #1;
        chk("u5_abort_busy", {31'b0, busy5}, 32'h0);
        chk("u5_abort_adr", {6'b0, adr5}, 32'h0);
        chk("u5_abort_done", {31'b0, done5}, 32'h0);
        salt5 = 16'h0000;
        tick;
        #2 clrn5 = 1'b1;
        tick;
        chk("u5_restart_adr0", {6'b0, adr5}, 32'h0);
        tick;
        chk("u5_restart_adr1", {6'b0, adr5}, 32'h1);
        c5 = 0;
        while (done5 !== 1'b1 && c5 < 40) begin
            tick;
            c5++;
        end
        chk("u5_done", {31'b0, done5}, 32'h1);
        a = 32'h0;
        #1;
        chk("u5_word0", inst5, 32'h0001_0000);
        a = 32'hC;
        #1;
        chk("u5_word3", inst5, 32'h0007_0006);
        a = 32'h1C;
        #1;
        chk("u5_word7", inst5, 32'h000F_000E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
